fejkon_fc_stats: RTL and testbench
==================================

Name: fejkon_fc_stats

Overview:
Passthrough monitor directly downstream of the FC debug injection mux, on the 256-bit channelised Avalon-ST frame stream. Adds one register stage, forwards every beat unmodified, and keeps per-channel packet, byte and framing-error counters. Counters are readable and clearable over the 8-bit-address CSR bus so software can verify generator and traffic throughput per channel.

Parameters:
NUM_CHANNELS, 16, channels with counters (1..16); beats on channel >= NUM_CHANNELS are forwarded but not counted
BEAT_BYTES, 32, bytes per data beat; byte count per beat = BEAT_BYTES - empty on EOP beats, BEAT_BYTES otherwise

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
st_in_channel  in  4  sink channel
st_in_data  in  256  sink data
st_in_startofpacket  in  1  sink SOP
st_in_endofpacket  in  1  sink EOP
st_in_empty  in  5  sink empty bytes (valid on EOP)
st_in_valid  in  1  sink valid
st_in_ready  out  1  sink ready
st_out_channel  out  4  source channel
st_out_data  out  256  source data
st_out_startofpacket  out  1  source SOP
st_out_endofpacket  out  1  source EOP
st_out_empty  out  5  source empty
st_out_valid  out  1  source valid
st_out_ready  in  1  source ready
csr_address  in  8  {channel[3:0], reg[3:0]}
csr_write  in  1  CSR write strobe
csr_read  in  1  CSR read strobe
csr_writedata  in  32  CSR write data
csr_readdata  out  32  CSR read data, registered

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset: st_out_valid=0, csr_readdata=0, all counters=0, all in_pkt flags=0. Data/channel/sop/eop/empty registers need no reset.
- Datapath: single output register. st_in_ready = ~reset & (~st_out_valid | st_out_ready), combinational. Accept = st_in_valid & st_in_ready. On st_in_ready, the output register loads all sink fields, with st_out_valid <= st_in_valid. Latency 1 cycle. Full throughput, one beat per cycle, under continuous ready.
- Output fields hold stable while st_out_valid & ~st_out_ready.
- Statistics update on accept, on channel c = st_in_channel, only if c < NUM_CHANNELS:
  - bytes[c] += eop ? (BEAT_BYTES - empty) : BEAT_BYTES. empty=0 on EOP counts 32.
  - Error on sop=1 with in_pkt[c]=1 (missing EOP): errors[c]+=1. The packet restarts.
  - Error on sop=0 with in_pkt[c]=0 (orphan beat): errors[c]+=1. Bytes are still counted.
  - packets[c] += 1 when eop=1 and (sop=1 or in_pkt[c]=1).
  - in_pkt[c] next = ~eop & (sop | in_pkt[c]).
  - The beat is always forwarded; the block never drops or alters traffic.
- Counters are 32-bit and saturate at 0xFFFFFFFF (no wrap). A byte add that would exceed saturates.
- CSR registers per channel ch: reg 0 packets, reg 1 bytes, reg 2 errors, reg 3 status (bit0 = in_pkt[ch]).
- CSR global register at address 0xFF: read returns NUM_CHANNELS.
- CSR reads: readdata is loaded on the cycle after csr_read and holds otherwise. Unmapped address or ch >= NUM_CHANNELS returns 0xFFFFFFFF.
- CSR writes: any write to reg 0xF of channel ch clears that channel's packets, bytes and errors; in_pkt is untouched. A write to 0xFF clears all channels. Other writes are ignored.
- Simultaneous clear and increment on the same channel: clear wins, and the counter becomes 0, not 1.
- Simultaneous read and increment: the read returns the pre-increment value.
- Reset mid-packet: in_pkt flags are cleared, so a continuation beat after reset counts as an orphan error.

Decomposition:
- Package fejkon_fc_pkg holds: BEAT_BYTES, register offset constants (REG_PACKETS=0, REG_BYTES=1, REG_ERRORS=2, REG_STATUS=3, REG_CLEAR=4'hF, ADDR_INFO=8'hFF), and a typedef of the per-channel counter struct {packets, bytes, errors}.
- Sub-module fejkon_fc_stats_counter: 32-bit saturating accumulator with synchronous clear (clear priority) and a 6-bit increment input, instantiated 3×NUM_CHANNELS.

Test Plan:
1. A single-beat packet on ch 2 (sop=eop=1, empty=4) -> the beat appears at output 1 cycle later, unchanged; ch2 packets=1, bytes=28, errors=0.
2. A 3-beat packet on ch 5 (empty=0 on EOP) with st_out_ready low for 2 cycles mid-packet -> output is held stable, no beat is lost or duplicated; packets=1, bytes=96.
3. On ch 1, sop, sop, eop (missing EOP) followed by one orphan beat with sop=0,eop=1 -> errors=2, packets=1, and all 4 beats are forwarded.
4. Preload ch 0 bytes to 0xFFFFFFF0, then send a 32-byte beat -> bytes=0xFFFFFFFF, held at saturation by further traffic.
5. In the same cycle, write to address 0x3F and accept a ch 3 EOP -> ch3 packets=0; a read of 0x30 returns 0 one cycle later.
6. Read 0xFF -> 16; read 0x36 -> 0xFFFFFFFF. Assert reset mid-packet on ch 7, then send a continuation beat -> ch7 errors=1.

Source files
------------

// File: rtl/fejkon_fc_pkg.sv
// Shared constants and types for the FC stream statistics monitor.
// Register map: address = {channel[3:0], reg[3:0]}, plus one global info word.
package fejkon_fc_pkg;

    localparam int BEAT_BYTES = 32;

    localparam logic [3:0] REG_PACKETS = 4'h0;
    localparam logic [3:0] REG_BYTES   = 4'h1;
    localparam logic [3:0] REG_ERRORS  = 4'h2;
    localparam logic [3:0] REG_STATUS  = 4'h3;
    localparam logic [3:0] REG_CLEAR   = 4'hF;
    localparam logic [7:0] ADDR_INFO   = 8'hFF;

    typedef struct packed {
        logic [31:0] packets;
        logic [31:0] bytes;
        logic [31:0] errors;
    } fc_counters_t;

endpackage

// File: rtl/fejkon_fc_stats_counter.sv
// 32-bit saturating accumulator with synchronous clear.
// Clear takes priority over a same-cycle increment.
module fejkon_fc_stats_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic [5:0]  i_inc,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [5:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {27'd0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc != 6'd0) begin
            r_count <= sat_add(r_count, i_inc);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fejkon_fc_stats.sv
// Passthrough register stage on the channelised FC frame stream that keeps
// per-channel packet, byte and framing-error counters readable over CSR.
module fejkon_fc_stats
    import fejkon_fc_pkg::*;
#(
    parameter int NUM_CHANNELS = 16
) (
    input  logic         clk,
    input  logic         reset,

    input  logic [3:0]   st_in_channel,
    input  logic [255:0] st_in_data,
    input  logic         st_in_startofpacket,
    input  logic         st_in_endofpacket,
    input  logic [4:0]   st_in_empty,
    input  logic         st_in_valid,
    output logic         st_in_ready,

    output logic [3:0]   st_out_channel,
    output logic [255:0] st_out_data,
    output logic         st_out_startofpacket,
    output logic         st_out_endofpacket,
    output logic [4:0]   st_out_empty,
    output logic         st_out_valid,
    input  logic         st_out_ready,

    input  logic [7:0]   csr_address,
    input  logic         csr_write,
    input  logic         csr_read,
    input  logic [31:0]  csr_writedata,
    output logic [31:0]  csr_readdata
);

    logic                    w_in_ready;
    logic                    w_accept;
    logic [5:0]              w_beat_bytes;
    logic [NUM_CHANNELS-1:0] w_in_pkt;
    fc_counters_t            w_cnt [NUM_CHANNELS];
    logic [31:0]             w_rdata;
    logic                    w_unused_wdata;

    logic                    r_out_valid;
    logic [3:0]              r_out_channel;
    logic [255:0]            r_out_data;
    logic                    r_out_sop;
    logic                    r_out_eop;
    logic [4:0]              r_out_empty;
    logic [31:0]             r_readdata;

    // Clearing is triggered by the strobe alone; the data value carries no meaning.
    assign w_unused_wdata = ^csr_writedata;

    assign w_in_ready   = ~reset & (~r_out_valid | st_out_ready);
    assign w_accept     = st_in_valid & w_in_ready;
    assign w_beat_bytes = st_in_endofpacket ? (6'(BEAT_BYTES) - {1'b0, st_in_empty})
                                            : 6'(BEAT_BYTES);

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_out_valid <= st_in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_ready) begin
            r_out_channel <= st_in_channel;
            r_out_data    <= st_in_data;
            r_out_sop     <= st_in_startofpacket;
            r_out_eop     <= st_in_endofpacket;
            r_out_empty   <= st_in_empty;
        end
    end

    assign st_in_ready          = w_in_ready;
    assign st_out_valid         = r_out_valid;
    assign st_out_channel       = r_out_channel;
    assign st_out_data          = r_out_data;
    assign st_out_startofpacket = r_out_sop;
    assign st_out_endofpacket   = r_out_eop;
    assign st_out_empty         = r_out_empty;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic         w_hit;
        logic         w_err;
        logic         w_pkt;
        logic         w_clear;
        fc_counters_t w_c;
        logic         r_in_pkt;

        // SOP while in a packet, or a non-SOP beat outside one, is a framing error.
        assign w_hit   = w_accept && (st_in_channel == 4'(g));
        assign w_err   = w_hit && (st_in_startofpacket == r_in_pkt);
        assign w_pkt   = w_hit && st_in_endofpacket && (st_in_startofpacket || r_in_pkt);
        assign w_clear = csr_write && ((csr_address == ADDR_INFO) ||
                                       (csr_address == {4'(g), REG_CLEAR}));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_in_pkt <= 1'b0;
            end else if (w_hit) begin
                r_in_pkt <= ~st_in_endofpacket & (st_in_startofpacket | r_in_pkt);
            end
        end

        fejkon_fc_stats_counter u_packets (
            .clk     (clk),
            .reset   (reset),
            .i_clear (w_clear),
            .i_inc   ({5'd0, w_pkt}),
            .o_count (w_c.packets)
        );

        fejkon_fc_stats_counter u_bytes (
            .clk     (clk),
            .reset   (reset),
            .i_clear (w_clear),
            .i_inc   (w_hit ? w_beat_bytes : 6'd0),
            .o_count (w_c.bytes)
        );

        fejkon_fc_stats_counter u_errors (
            .clk     (clk),
            .reset   (reset),
            .i_clear (w_clear),
            .i_inc   ({5'd0, w_err}),
            .o_count (w_c.errors)
        );

        assign w_cnt[g]    = w_c;
        assign w_in_pkt[g] = r_in_pkt;
    end

    always_comb begin
        w_rdata = 32'hFFFF_FFFF;
        if (csr_address == ADDR_INFO) begin
            w_rdata = 32'(NUM_CHANNELS);
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (csr_address[7:4] == 4'(i)) begin
                    case (csr_address[3:0])
                        REG_PACKETS: w_rdata = w_cnt[i].packets;
                        REG_BYTES:   w_rdata = w_cnt[i].bytes;
                        REG_ERRORS:  w_rdata = w_cnt[i].errors;
                        REG_STATUS:  w_rdata = {31'd0, w_in_pkt[i]};
                        default:     w_rdata = 32'hFFFF_FFFF;
                    endcase
                end
            end
        end
    end

    // CSR read register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (csr_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign csr_readdata = r_readdata;

endmodule

// File: tb/tb_fejkon_fc_stats.sv
// Directed bench for fejkon_fc_stats: forwarding, stalls, framing errors,
// saturation, clear/increment races, CSR map and reset mid-packet.
module tb_fejkon_fc_stats;

    logic         clk;
    logic         reset;
    logic [3:0]   st_in_channel;
    logic [255:0] st_in_data;
    logic         st_in_startofpacket;
    logic         st_in_endofpacket;
    logic [4:0]   st_in_empty;
    logic         st_in_valid;
    logic         st_in_ready;
    logic [3:0]   st_out_channel;
    logic [255:0] st_out_data;
    logic         st_out_startofpacket;
    logic         st_out_endofpacket;
    logic [4:0]   st_out_empty;
    logic         st_out_valid;
    logic         st_out_ready;
    logic [7:0]   csr_address;
    logic         csr_write;
    logic         csr_read;
    logic [31:0]  csr_writedata;
    logic [31:0]  csr_readdata;

    int n_chk  = 0;
    int n_pass = 0;
    int n_xfer = 0;
    int x0;

    fejkon_fc_stats dut (
        .clk                  (clk),
        .reset                (reset),
        .st_in_channel        (st_in_channel),
        .st_in_data           (st_in_data),
        .st_in_startofpacket  (st_in_startofpacket),
        .st_in_endofpacket    (st_in_endofpacket),
        .st_in_empty          (st_in_empty),
        .st_in_valid          (st_in_valid),
        .st_in_ready          (st_in_ready),
        .st_out_channel       (st_out_channel),
        .st_out_data          (st_out_data),
        .st_out_startofpacket (st_out_startofpacket),
        .st_out_endofpacket   (st_out_endofpacket),
        .st_out_empty         (st_out_empty),
        .st_out_valid         (st_out_valid),
        .st_out_ready         (st_out_ready),
        .csr_address          (csr_address),
        .csr_write            (csr_write),
        .csr_read             (csr_read),
        .csr_writedata        (csr_writedata),
        .csr_readdata         (csr_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (st_out_valid && st_out_ready) n_xfer <= n_xfer + 1;
    end

    function automatic logic [255:0] pat(input logic [7:0] k);
        return {16{k, ~k}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drv(input logic [3:0] ch, input logic sop, input logic eop,
                       input logic [4:0] emp, input logic [255:0] d);
        st_in_channel       = ch;
        st_in_startofpacket = sop;
        st_in_endofpacket   = eop;
        st_in_empty         = emp;
        st_in_data          = d;
        st_in_valid         = 1'b1;
    endtask

    task automatic idle();
        st_in_valid         = 1'b0;
        st_in_startofpacket = 1'b0;
        st_in_endofpacket   = 1'b0;
        st_in_empty         = 5'd0;
    endtask

    // Drive one beat with the sink ready and check it on the output a cycle later.
    task automatic beat(input logic [3:0] ch, input logic sop, input logic eop,
                        input logic [4:0] emp, input logic [255:0] d);
        drv(ch, sop, eop, emp, d);
        @(negedge clk);
        chk("fwd_data", st_out_data, d);
        chk("fwd_ctrl",
            256'({st_out_valid, st_out_channel, st_out_startofpacket, st_out_endofpacket, st_out_empty}),
            256'({1'b1, ch, sop, eop, emp}));
    endtask

    task automatic csr_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        csr_address = a;
        csr_read    = 1'b1;
        @(negedge clk);
        csr_read    = 1'b0;
        chk(tag, 256'(csr_readdata), 256'(exp));
    endtask

    initial begin
        reset         = 1'b1;
        st_out_ready  = 1'b1;
        st_in_channel = 4'd0;
        st_in_data    = '0;
        idle();
        csr_address   = 8'd0;
        csr_write     = 1'b0;
        csr_read      = 1'b0;
        csr_writedata = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 256'(st_out_valid), 256'(1'b0));
        chk("rst_ready", 256'(st_in_ready), 256'(1'b0));
        chk("rst_rdata", 256'(csr_readdata), 256'(32'd0));
        reset = 1'b0;
        @(negedge clk);

        // single-beat packet on ch2, empty=4
        chk("t1_pre_valid", 256'(st_out_valid), 256'(1'b0));
        beat(4'd2, 1'b1, 1'b1, 5'd4, pat(8'h11));
        idle();
        csr_rd("t1_pkts",  8'h20, 32'd1);
        csr_rd("t1_bytes", 8'h21, 32'd28);
        csr_rd("t1_errs",  8'h22, 32'd0);

        // 3-beat packet on ch5 with a two-cycle output stall
        x0 = n_xfer;
        drv(4'd5, 1'b1, 1'b0, 5'd0, pat(8'h21));
        @(negedge clk);
        chk("t2_a", st_out_data, pat(8'h21));
        drv(4'd5, 1'b0, 1'b0, 5'd0, pat(8'h22));
        st_out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t2_hold_data", st_out_data, pat(8'h21));
            chk("t2_hold_valid", 256'({st_out_valid, st_out_startofpacket}), 256'(2'b11));
            chk("t2_stall_ready", 256'(st_in_ready), 256'(1'b0));
        end
        st_out_ready = 1'b1;
        @(negedge clk);
        chk("t2_b", st_out_data, pat(8'h22));
        drv(4'd5, 1'b0, 1'b1, 5'd0, pat(8'h23));
        @(negedge clk);
        chk("t2_c", st_out_data, pat(8'h23));
        idle();
        @(negedge clk);
        chk("t2_drained", 256'(st_out_valid), 256'(1'b0));
        chk("t2_xfers", 256'(n_xfer - x0), 256'(3));
        csr_rd("t2_pkts",  8'h50, 32'd1);
        csr_rd("t2_bytes", 8'h51, 32'd96);
        csr_rd("t2_errs",  8'h52, 32'd0);

        // missing EOP then orphan beat on ch1
        x0 = n_xfer;
        beat(4'd1, 1'b1, 1'b0, 5'd0, pat(8'h31));
        beat(4'd1, 1'b1, 1'b0, 5'd0, pat(8'h32));
        beat(4'd1, 1'b0, 1'b1, 5'd0, pat(8'h33));
        beat(4'd1, 1'b0, 1'b1, 5'd0, pat(8'h34));
        idle();
        @(negedge clk);
        chk("t3_xfers", 256'(n_xfer - x0), 256'(4));
        csr_rd("t3_pkts",   8'h10, 32'd1);
        csr_rd("t3_bytes",  8'h11, 32'd128);
        csr_rd("t3_errs",   8'h12, 32'd2);
        csr_rd("t3_status", 8'h13, 32'd0);

        // byte counter saturation on ch0
        force dut.g_ch[0].u_bytes.r_count = 32'hFFFF_FFF0;
        #1;
        release dut.g_ch[0].u_bytes.r_count;
        csr_rd("t4_preload", 8'h01, 32'hFFFF_FFF0);
        beat(4'd0, 1'b1, 1'b1, 5'd0, pat(8'h41));
        idle();
        csr_rd("t4_sat", 8'h01, 32'hFFFF_FFFF);
        beat(4'd0, 1'b1, 1'b1, 5'd16, pat(8'h42));
        idle();
        csr_rd("t4_sat_hold", 8'h01, 32'hFFFF_FFFF);
        csr_rd("t4_pkts",     8'h00, 32'd2);

        // clear racing an increment on ch3, then read racing an increment
        beat(4'd3, 1'b1, 1'b1, 5'd0, pat(8'h51));
        idle();
        csr_rd("t5_pre", 8'h30, 32'd1);
        drv(4'd3, 1'b1, 1'b1, 5'd0, pat(8'h52));
        csr_address   = 8'h3F;
        csr_writedata = 32'h1;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
        idle();
        chk("t5_fwd", st_out_data, pat(8'h52));
        csr_rd("t5_clr_pkts",  8'h30, 32'd0);
        csr_rd("t5_clr_bytes", 8'h31, 32'd0);
        drv(4'd3, 1'b1, 1'b1, 5'd0, pat(8'h53));
        csr_address = 8'h30;
        csr_read    = 1'b1;
        @(negedge clk);
        csr_read = 1'b0;
        idle();
        chk("t5_rd_pre_inc", 256'(csr_readdata), 256'(32'd0));
        csr_rd("t5_post_inc",  8'h30, 32'd1);
        csr_rd("t5_bytes",     8'h31, 32'd32);
        csr_address = 8'hFF;
        csr_write   = 1'b1;
        @(negedge clk);
        csr_write = 1'b0;
        csr_rd("t5_clrall_errs", 8'h12, 32'd0);
        csr_rd("t5_clrall_pkts", 8'h20, 32'd0);
        csr_rd("t5_clrall_c15",  8'hF1, 32'd0);

        // CSR map and reset mid-packet on ch7
        csr_rd("t6_info",     8'hFF, 32'd16);
        csr_rd("t6_unmapped", 8'h36, 32'hFFFF_FFFF);
        csr_rd("t6_regf",     8'h7F, 32'hFFFF_FFFF);
        beat(4'd7, 1'b1, 1'b0, 5'd0, pat(8'h61));
        idle();
        csr_rd("t6_inpkt", 8'h73, 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_valid", 256'(st_out_valid), 256'(1'b0));
        csr_rd("t6_inpkt_rst", 8'h73, 32'd0);
        beat(4'd7, 1'b0, 1'b1, 5'd0, pat(8'h62));
        idle();
        csr_rd("t6_errs",  8'h72, 32'd1);
        csr_rd("t6_pkts",  8'h70, 32'd0);
        csr_rd("t6_bytes", 8'h71, 32'd32);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
